i2s_audio_tx: RTL
=================

Name: i2s_audio_tx

Overview:
- Consumer end of the 16-bit signed audio sample stream produced by the tone generators.
- Accepts stereo samples through a valid/ready handshake into a one-entry holding register.
- Serialises each sample pair as a standard I2S frame (bclk, lrclk, sdata) to the board DAC.
- The block is the bclk/lrclk master. Frame rate fs = CLK_FREQ / (2 * BCLK_HALF_DIV * 64).

Parameters:
- CLK_FREQ, 125_000_000: system clock in Hz. Documentation and assertions only.
- BCLK_HALF_DIV, 20: clk cycles per bclk half-period, must be ≥2. Default gives bclk = 3.125 MHz and fs ≈ 48.83 kHz.
- SAMPLE_W, 16: sample width; must be ≤ 31.

Ports:
- clk, input, 1: system clock. The block uses this one clock only.
- reset, input, 1: asynchronous, active-high reset.
- sample_l, input, SAMPLE_W: signed left sample.
- sample_r, input, SAMPLE_W: signed right sample.
- sample_valid, input, 1: producer has a sample pair.
- sample_ready, output, 1: holding register empty; a write is accepted on valid & ready.
- i2s_bclk, output, 1: bit clock.
- i2s_lrclk, output, 1: word select; 0 = left, 1 = right.
- i2s_sdata, output, 1: serial data, MSB first.
- underrun, output, 1: one-clk pulse when a frame starts with no sample held.

Behaviour:
- Reset values (asynchronous): i2s_bclk=0, i2s_lrclk=1, i2s_sdata=0, underrun=0, holding register empty (sample_ready=1), divider count=0, slot counter=63, frame data=0.
- Divider: count runs 0..BCLK_HALF_DIV-1. At terminal count it wraps to 0 and i2s_bclk toggles.
- A 1→0 toggle asserts an internal fall_tick for that clk cycle.
- The first rising bclk occurs BCLK_HALF_DIV clks after reset release; the first falling edge occurs at 2*BCLK_HALF_DIV.
- All lrclk/sdata updates happen only in the fall_tick cycle, registered alongside the bclk falling edge. The DAC samples on the rising edge.
- Slot counter: 6-bit, increments on fall_tick and wraps 63→0.
- i2s_lrclk = 0 for slots 0..31 and 1 for slots 32..63.
- sdata mapping (one-bclk I2S delay):
  - slot n in 1..SAMPLE_W: frame_l[SAMPLE_W-n]
  - slot n in 33..32+SAMPLE_W: frame_r[SAMPLE_W-(n-32)]
  - all other slots: 0
- Frame load happens in the fall_tick cycle where the slot goes 63→0:
  - Holding full: frame_l/frame_r ← holding register, holding marked empty.
  - Holding empty: frame_l/frame_r ← 0 and underrun=1 for that one clk.
- Handshake:
  - sample_ready = holding empty; it is a register output with no combinational path from sample_valid.
  - Accept on sample_valid & sample_ready: capture both samples, set full, and sample_ready drops the next cycle.
  - The producer must hold its data while valid & !ready. The block itself tolerates valid being withdrawn.
- Simultaneous load and write:
  - Holding empty at load: underrun fires and the same-cycle write still fills holding for the next frame.
  - Holding full at load: ready=0, so no write is possible; holding empties and ready rises the next cycle.
- A sample is never dropped or duplicated. Each accepted pair appears in exactly one frame, in order.
- Reset mid-frame: all state returns to reset values immediately. A pending holding sample is discarded.
- Steady state is one accept per frame (every 64 bclk). A producer at an equal or faster rate never causes underrun.

Decomposition:
- Shared package audio_pkg:
  - SAMPLE_W = 16
  - I2S_SLOT_BITS = 32
  - I2S_FRAME_BITS = 64
  - typedef signed sample_t [SAMPLE_W-1:0]
- Sub-module i2s_clk_gen (parameter BCLK_HALF_DIV):
  - Generates i2s_bclk, fall_tick, the slot counter and i2s_lrclk.
  - The top level holds the handshake, holding register, frame registers and sdata mux.

Test Plan:
- Reset then idle (BCLK_HALF_DIV=20, no valid):
  - i2s_bclk period is 40 clks.
  - First falling edge at clk 40 goes to slot 0, lrclk 1→0, underrun pulses once.
  - sdata stays 0 for the whole frame.
  - underrun repeats every 2560 clks.
- Single pair (L=16'h8001, R=16'h7FFE) written before the first frame start:
  - Left slots 1..16 carry 1000000000000001.
  - Right slots 33..48 carry 0111111111111110.
  - Other slots are 0 and no underrun occurs.
- Back-pressure (valid held high continuously, L=R=incrementing counter):
  - ready falls one clk after each accept and rises one clk after each frame load.
  - Frames show 0,1,2,3… with no gaps, repeats or underrun.
- Write coincident with load while holding empty:
  - underrun=1 in that cycle.
  - The written pair appears in the following frame, not the current one.
- Async reset asserted at slot 40 while holding is full:
  - Outputs reach reset values without a clk edge.
  - The held sample never appears on sdata after release.
- BCLK_HALF_DIV=2:
  - bclk period is 4 clks and the frame is 256 clks.
  - Bit mapping is identical to the scenario above.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared audio sample type and I2S frame geometry
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_FRAME_BITS = 64;
  typedef logic signed [SAMPLE_W-1:0] sample_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// i2s_clk_gen: bclk divider, falling-edge tick, 64-slot counter and lrclk
module i2s_clk_gen
  import audio_pkg::*;
#(
  parameter int BCLK_HALF_DIV = 20
) (
  input  logic       clk,
  input  logic       reset,
  output logic       i2s_bclk,
  output logic       fall_tick,
  output logic [5:0] slot,
  output logic       i2s_lrclk
);
  localparam int CW = BCLK_HALF_DIV > 1 ? $clog2(BCLK_HALF_DIV) : 1;
  logic [CW-1:0] cnt;
  logic          tc;
  logic [5:0]    slot_nxt;
  assign tc        = cnt == CW'(BCLK_HALF_DIV - 1);
  assign fall_tick = tc && i2s_bclk;
  assign slot_nxt  = slot + 6'd1;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt       <= '0;
      i2s_bclk  <= 1'b0;
      slot      <= 6'd63;
      i2s_lrclk <= 1'b1;
    end else begin
      cnt <= tc ? '0 : cnt + CW'(1);
      if (tc) i2s_bclk <= ~i2s_bclk;
      if (fall_tick) begin
        slot      <= slot_nxt;
        i2s_lrclk <= slot_nxt >= 6'(I2S_SLOT_BITS);
      end
    end
endmodule

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: one-entry stereo sample holding register serialised as I2S master frames
module i2s_audio_tx #(
  parameter int CLK_FREQ      = 125_000_000,
  parameter int BCLK_HALF_DIV = 20,
  parameter int SAMPLE_W      = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic signed [SAMPLE_W-1:0] sample_l,
  input  logic signed [SAMPLE_W-1:0] sample_r,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  output logic                       i2s_bclk,
  output logic                       i2s_lrclk,
  output logic                       i2s_sdata,
  output logic                       underrun
);
  localparam int SB = audio_pkg::I2S_SLOT_BITS;
  if (BCLK_HALF_DIV < 2 || SAMPLE_W > SB - 1 || CLK_FREQ < 1) begin : g_bad_params
    $error("i2s_audio_tx: BCLK_HALF_DIV must be >= 2 and SAMPLE_W <= 31");
  end
  logic                fall_tick, load, wr;
  logic [5:0]          slot, slot_nxt;
  logic [SAMPLE_W-1:0] hold_l, hold_r, frame_l, frame_r;
  logic [2*SB-1:0]     frame_word;
  i2s_clk_gen #(.BCLK_HALF_DIV(BCLK_HALF_DIV)) u_clk_gen (
    .clk       (clk),
    .reset     (reset),
    .i2s_bclk  (i2s_bclk),
    .fall_tick (fall_tick),
    .slot      (slot),
    .i2s_lrclk (i2s_lrclk)
  );
  assign slot_nxt = slot + 6'd1;
  assign load     = fall_tick && slot == 6'd63;
  assign wr       = sample_valid && sample_ready;
  // Each half-frame is a 32-bit word, MSB sent in slot 0: a zero pad bit gives the one-bclk I2S delay
  assign frame_word = {SB'({1'b0, frame_l}) << (SB - 1 - SAMPLE_W),
                       SB'({1'b0, frame_r}) << (SB - 1 - SAMPLE_W)};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sample_ready <= 1'b1;
      hold_l       <= '0;
      hold_r       <= '0;
      frame_l      <= '0;
      frame_r      <= '0;
      i2s_sdata    <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      underrun     <= load && sample_ready;
      sample_ready <= wr ? 1'b0 : load ? 1'b1 : sample_ready;
      if (load) begin
        frame_l <= sample_ready ? '0 : hold_l;
        frame_r <= sample_ready ? '0 : hold_r;
      end
      if (wr) begin
        hold_l <= sample_l;
        hold_r <= sample_r;
      end
      if (fall_tick) i2s_sdata <= frame_word[~slot_nxt];
    end
endmodule
